// File: rtl/csr_diff_pkg.sv
// rtl/csr_diff_pkg.sv - shared CSR index, snapshot and FSM types for csr_diff_sequencer
package csr_diff_pkg;

  localparam int CSR_DIFF_NCSR = 18;
  localparam int CSR_DIFF_XLEN = 64;

  typedef enum logic [4:0] {
    CSR_PRIV     = 5'd0,
    CSR_MSTATUS  = 5'd1,
    CSR_SSTATUS  = 5'd2,
    CSR_MEPC     = 5'd3,
    CSR_SEPC     = 5'd4,
    CSR_MTVAL    = 5'd5,
    CSR_STVAL    = 5'd6,
    CSR_MTVEC    = 5'd7,
    CSR_STVEC    = 5'd8,
    CSR_MCAUSE   = 5'd9,
    CSR_SCAUSE   = 5'd10,
    CSR_SATP     = 5'd11,
    CSR_MIP      = 5'd12,
    CSR_MIE      = 5'd13,
    CSR_MSCRATCH = 5'd14,
    CSR_SSCRATCH = 5'd15,
    CSR_MIDELEG  = 5'd16,
    CSR_MEDELEG  = 5'd17
  } csr_idx_e;

  typedef logic [CSR_DIFF_NCSR-1:0][CSR_DIFF_XLEN-1:0] csr_snap_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } seq_state_e;

endpackage

// File: rtl/csr_snap_fifo.sv
// rtl/csr_snap_fifo.sv - DEPTH-entry CSR snapshot FIFO with occupancy count and head read
module csr_snap_fifo
  import csr_diff_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NCSR  = CSR_DIFF_NCSR,
  parameter int XLEN  = CSR_DIFF_XLEN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [NCSR-1:0][XLEN-1:0]     data_i,
  input  logic                          pop_i,
  output logic [NCSR-1:0][XLEN-1:0]     head_o,
  output logic [$clog2(DEPTH):0]        cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [NCSR-1:0][XLEN-1:0] mem_q [DEPTH];
  logic [AW-1:0]             wr_ptr_q;
  logic [AW-1:0]             rd_ptr_q;
  logic [CW-1:0]             cnt_q;
  logic                      do_push;
  logic                      do_pop;

  // Full blocks a push even when a pop lands in the same cycle.
  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o = mem_q[rd_ptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/csr_diff_sequencer.sv
// rtl/csr_diff_sequencer.sv - queues per-commit CSR snapshots and drains them as (idx, data) beats; option CSR_DIFF_SKIP_UNCHANGED_EN
module csr_diff_sequencer
  import csr_diff_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NCSR  = CSR_DIFF_NCSR,
  parameter int XLEN  = CSR_DIFF_XLEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     commit_valid,
  output logic                     commit_ready,
  input  logic [NCSR*XLEN-1:0]     commit_csr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_idx,
  output logic [XLEN-1:0]          out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [NCSR-1:0][XLEN-1:0] head;
  logic [CW-1:0]             cnt;
  seq_state_e                state_q, state_d;
  logic [4:0]                beat_q, beat_d;
  logic [4:0]                sel_idx;
  logic                      sel_last;
  logic                      push;
  logic                      pop;

  assign commit_ready = (cnt != CW'(DEPTH));
  assign push         = commit_valid & commit_ready;
  assign pop          = (state_q == SEND) & out_ready & sel_last;

  csr_snap_fifo #(
    .DEPTH (DEPTH),
    .NCSR  (NCSR),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .data_i (commit_csr),
    .pop_i  (pop),
    .head_o (head),
    .cnt_o  (cnt)
  );

`ifdef CSR_DIFF_SKIP_UNCHANGED_EN
  logic [NCSR-1:0][XLEN-1:0] shadow_q;
  logic [NCSR-1:0]           diff;
  logic                      later;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   shadow_q <= '0;
    else if (pop) shadow_q <= head;
  end

  // beat_q is the search start; the beat shown is the first differing CSR at or after it.
  always_comb begin
    diff    = '0;
    sel_idx = '0;
    later   = 1'b0;
    for (int i = 0; i < NCSR; i++) diff[i] = (head[i] != shadow_q[i]);
    for (int i = NCSR - 1; i >= 0; i--) begin
      if (diff[i] && (5'(i) >= beat_q)) sel_idx = 5'(i);
    end
    for (int i = 0; i < NCSR; i++) begin
      if (diff[i] && (5'(i) > sel_idx)) later = 1'b1;
    end
    sel_last = ~later;
  end
`else
  always_comb begin
    sel_idx  = beat_q;
    sel_last = (beat_q == 5'(NCSR - 1));
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (cnt != '0) state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (sel_last) begin
            beat_d = '0;
            // A same-cycle push keeps the stream going with no bubble.
            if ((cnt == CW'(1)) && !push) state_d = IDLE;
          end else begin
            beat_d = sel_idx + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == SEND);
  assign out_idx   = out_valid ? sel_idx : '0;
  assign out_data  = out_valid ? head[sel_idx] : '0;
  assign out_last  = out_valid & sel_last;
  assign fifo_cnt  = cnt;

endmodule

// File: tb/tb_csr_diff_sequencer.sv
// tb/tb_csr_diff_sequencer.sv - randomized self-checking bench for csr_diff_sequencer against a queue model
module tb_csr_diff_sequencer;
  import csr_diff_pkg::*;

  localparam int DEPTH = 4;
  localparam int NCSR  = CSR_DIFF_NCSR;
  localparam int XLEN  = CSR_DIFF_XLEN;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef CSR_DIFF_SKIP_UNCHANGED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
    logic            last;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   commit_valid = 1'b0;
  logic                   commit_ready;
  logic [NCSR*XLEN-1:0]   commit_csr = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [4:0]             out_idx;
  logic [XLEN-1:0]        out_data;
  logic                   out_last;
  logic [CW-1:0]          fifo_cnt;

  int        total = 0;
  int        bad = 0;
  beat_t     exp_q[$];
  int        mcnt = 0;
  csr_snap_t shadow = '0;

  csr_diff_sequencer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_csr   (commit_csr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_data     (out_data),
    .out_last     (out_last),
    .fifo_cnt     (fifo_cnt)
  );

  always #5 clk = ~clk;

  function automatic csr_snap_t make_snap(logic [XLEN-1:0] base);
    csr_snap_t s;
    for (int i = 0; i < NCSR; i++) s[i] = base + XLEN'(i);
    return s;
  endfunction

  function automatic void gen_beats(csr_snap_t s);
    beat_t b;
    int    n = 0;
    for (int i = 0; i < NCSR; i++) begin
      if (!SKIP || (s[i] != shadow[i])) begin
        b.idx = 5'(i); b.data = s[i]; b.last = 1'b0;
        exp_q.push_back(b);
        n++;
      end
    end
    if (n == 0) begin
      b.idx = 5'd0; b.data = s[0]; b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      b = exp_q.pop_back();
      b.last = 1'b1;
      exp_q.push_back(b);
    end
    shadow = s;
  endfunction

  // Called #1 after a rising edge with inputs already applied; advances one clock.
  task automatic cycle();
    beat_t b;
    total++;
    if (commit_ready !== (mcnt != DEPTH)) begin
      bad++;
      $display("FAIL commit_ready got=%0b exp=%0b", commit_ready, (mcnt != DEPTH));
    end
    if (commit_valid && (mcnt != DEPTH)) begin
      gen_beats(commit_csr);
      mcnt++;
    end
    if ((out_valid === 1'b1) && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected got idx=%0d exp=none", out_idx);
      end else begin
        b = exp_q.pop_front();
        if ((out_idx !== b.idx) || (out_data !== b.data) || (out_last !== b.last)) begin
          bad++;
          $display("FAIL beat got idx=%0d data=%h last=%0b exp idx=%0d data=%h last=%0b",
                   out_idx, out_data, out_last, b.idx, b.data, b.last);
        end
        if (b.last) mcnt--;
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (fifo_cnt !== CW'(mcnt)) begin
      bad++;
      $display("FAIL fifo_cnt got=%0d exp=%0d", fifo_cnt, mcnt);
    end
  endtask

  task automatic drain(string tag);
    int n = 0;
    commit_valid = 1'b0;
    out_ready = 1'b1;
    while (((mcnt != 0) || (exp_q.size() != 0)) && (n < 300)) begin
      cycle();
      n++;
    end
    total++;
    if ((mcnt != 0) || (exp_q.size() != 0) || (out_valid !== 1'b0)) begin
      bad++;
      $display("FAIL drain_%s got cnt=%0d valid=%0b pending=%0d exp all zero",
               tag, fifo_cnt, out_valid, exp_q.size());
    end
  endtask

  task automatic wait_idx(logic [4:0] idx, string tag);
    int n = 0;
    while (!((out_valid === 1'b1) && (out_idx === idx)) && (n < 100)) begin
      cycle();
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL wait_%s got idx=%0d valid=%0b exp idx=%0d", tag, out_idx, out_valid, idx);
    end
  endtask

  task automatic reset_and_check(string tag);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    mcnt = 0;
    shadow = '0;
    total++;
    if (({out_valid, out_last, out_idx, out_data, fifo_cnt} !== '0) || (commit_ready !== 1'b1)) begin
      bad++;
      $display("FAIL %s got valid=%0b last=%0b idx=%0d data=%h cnt=%0d rdy=%0b exp 0/0/0/0/0/1",
               tag, out_valid, out_last, out_idx, out_data, fifo_cnt, commit_ready);
    end
    commit_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    reset_and_check("reset_state");
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    commit_valid = 1'b1;
    commit_csr = make_snap(64'h1000);
    cycle();
    commit_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_latency got valid=%0b exp=0", out_valid);
    end
    cycle();
    total++;
    if ((out_valid !== 1'b1) || (out_idx !== 5'd0) || (out_data !== 64'h1000)) begin
      bad++;
      $display("FAIL single_first got valid=%0b idx=%0d data=%h exp 1/0/1000", out_valid, out_idx, out_data);
    end
    for (int i = 0; i < NCSR; i++) cycle();
    total++;
    if ((fifo_cnt !== '0) || (out_valid !== 1'b0) || (exp_q.size() != 0)) begin
      bad++;
      $display("FAIL single_done got cnt=%0d valid=%0b pending=%0d exp 0/0/0", fifo_cnt, out_valid, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    commit_valid = 1'b1;
    commit_csr = make_snap(64'h2000);
    cycle();
    commit_valid = 1'b0;
    wait_idx(5'd3, "bp");
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      total++;
      if ((out_valid !== 1'b1) || (out_idx !== 5'd3) || (out_data !== 64'h2003) || (out_last !== 1'b0)) begin
        bad++;
        $display("FAIL bp_hold got valid=%0b idx=%0d data=%h last=%0b exp 1/3/2003/0",
                 out_valid, out_idx, out_data, out_last);
      end
    end
    out_ready = 1'b1;
    cycle();
    total++;
    if ((out_idx !== 5'd4) || (out_data !== 64'h2004)) begin
      bad++;
      $display("FAIL bp_resume got idx=%0d data=%h exp 4/2004", out_idx, out_data);
    end
    drain("bp");
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    out_ready = 1'b1;
    commit_valid = 1'b1;
    commit_csr = make_snap(64'h6000);
    cycle();
    commit_valid = 1'b0;
    wait_idx(5'd7, "mid");
    reset_and_check("reset_mid");
    out_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (out_valid !== 1'b0) seen++;
      cycle();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid_quiet got valid_cycles=%0d exp=0", seen);
    end
  endtask

  task automatic test_fill();
    int n = 0;
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      commit_valid = 1'b1;
      commit_csr = make_snap(64'h3000 + 64'(k) * 64'h100);
      cycle();
    end
    total++;
    if ((commit_ready !== 1'b0) || (fifo_cnt !== CW'(DEPTH))) begin
      bad++;
      $display("FAIL fill_full got rdy=%0b cnt=%0d exp 0/%0d", commit_ready, fifo_cnt, DEPTH);
    end
    commit_csr = make_snap(64'h3400);
    cycle();
    // Keep offering while the head drains: the final pop must not admit a push.
    out_ready = 1'b1;
    while ((mcnt == DEPTH) && (n < 60)) begin
      cycle();
      n++;
    end
    commit_valid = 1'b0;
    total++;
    if ((commit_ready !== 1'b1) || (fifo_cnt !== CW'(DEPTH - 1))) begin
      bad++;
      $display("FAIL fill_after_pop got rdy=%0b cnt=%0d exp 1/%0d", commit_ready, fifo_cnt, DEPTH - 1);
    end
    drain("fill");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    out_ready = 1'b1;
    commit_valid = 1'b1;
    commit_csr = make_snap(64'h7000);
    cycle();
    commit_valid = 1'b0;
    while (!((out_valid === 1'b1) && (out_last === 1'b1)) && (n < 60)) begin
      cycle();
      n++;
    end
    commit_valid = 1'b1;
    commit_csr = make_snap(64'h7100);
    cycle();
    commit_valid = 1'b0;
    total++;
    if ((fifo_cnt !== CW'(1)) || (out_valid !== 1'b1) || (exp_q.size() == 0)) begin
      bad++;
      $display("FAIL b2b_nobubble got cnt=%0d valid=%0b exp 1/1", fifo_cnt, out_valid);
    end else if ((out_idx !== exp_q[0].idx) || (out_data !== exp_q[0].data)) begin
      bad++;
      $display("FAIL b2b_first got idx=%0d data=%h exp idx=%0d data=%h",
               out_idx, out_data, exp_q[0].idx, exp_q[0].data);
    end
    drain("b2b");
  endtask

`ifdef CSR_DIFF_SKIP_UNCHANGED_EN
  task automatic test_skip();
    csr_snap_t s;
    s = make_snap(64'h5000);
    out_ready = 1'b1;
    commit_valid = 1'b1;
    commit_csr = s;
    cycle();
    drain("skip1");
    s[CSR_MEPC] = 64'h8000_0100;
    for (int pass = 0; pass < 2; pass++) begin
      out_ready = 1'b0;
      commit_valid = 1'b1;
      commit_csr = s;
      cycle();
      commit_valid = 1'b0;
      cycle();
      total++;
      if (pass == 0) begin
        if ((out_valid !== 1'b1) || (out_idx !== 5'd3) || (out_last !== 1'b1) || (out_data !== 64'h8000_0100)) begin
          bad++;
          $display("FAIL skip_one got valid=%0b idx=%0d data=%h last=%0b exp 1/3/80000100/1",
                   out_valid, out_idx, out_data, out_last);
        end
      end else begin
        if ((out_valid !== 1'b1) || (out_idx !== 5'd0) || (out_last !== 1'b1) || (out_data !== s[0])) begin
          bad++;
          $display("FAIL skip_none got valid=%0b idx=%0d data=%h last=%0b exp 1/0/%h/1",
                   out_valid, out_idx, out_data, out_last, s[0]);
        end
      end
      drain("skip");
    end
  endtask
`endif

  task automatic test_random();
    csr_snap_t s;
    s = make_snap(64'h9000);
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < NCSR; i++) begin
        if ($urandom_range(0, 3) == 0) s[i] = {$urandom, $urandom};
      end
      commit_valid = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 7);
      commit_csr = s;
      cycle();
    end
    drain("random");
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_reset_midstream();
    test_fill();
    test_back_to_back();
`ifdef CSR_DIFF_SKIP_UNCHANGED_EN
    test_skip();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
